// File: rtl/blink_monitor_pkg.sv
// Shared types for the blink LED bus monitor.
//   BLINK_LED_W     default observed bus width
//   BLINK_PERIOD_W  default period counter / field width
//   blink_mon_state_t  monitor FSM states
//   blink_rec_t        one change record {value, step, period, first}
package blink_pkg;

  localparam int unsigned BLINK_LED_W    = 8;
  localparam int unsigned BLINK_PERIOD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE
  } blink_mon_state_t;

  typedef struct packed {
    logic [BLINK_LED_W-1:0]    value;
    logic [BLINK_LED_W-1:0]    step;
    logic [BLINK_PERIOD_W-1:0] period;
    logic                      first;
  } blink_rec_t;

endpackage

// File: rtl/blink_monitor_if.sv
// Record stream carried out of blink_monitor (valid/ready).
//   out_valid   record available (master -> slave)
//   out_ready   consumer accepts when out_valid && out_ready (slave -> master)
//   out_value   led value after the change
//   out_step    (new - old) mod 2**LED_W
//   out_period  cycles since the previous change, 0 on the first record
//   out_first   first record after arming
interface blink_monitor_if
  import blink_pkg::*;
#(
  parameter int unsigned LED_W    = BLINK_LED_W,
  parameter int unsigned PERIOD_W = BLINK_PERIOD_W
);
  logic                out_valid;
  logic                out_ready;
  logic [LED_W-1:0]    out_value;
  logic [LED_W-1:0]    out_step;
  logic [PERIOD_W-1:0] out_period;
  logic                out_first;

  modport master (
    output out_valid,
    output out_value,
    output out_step,
    output out_period,
    output out_first,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_value,
    input  out_step,
    input  out_period,
    input  out_first,
    output out_ready
  );
endinterface

// File: rtl/blink_mon_fifo.sv
// Two-entry synchronous FIFO holding packed change records.
// Entry 0 is always the head, so o_data is a plain register.
//   clk, rst_n  clock, asynchronous active-low reset
//   i_push      write i_data (accepted when not full, or when popping)
//   i_pop       remove head (ignored when empty)
//   i_flush     drop all entries
//   i_data      record in
//   o_data      head record
//   o_full      two entries held
//   o_empty     no entries held
module blink_mon_fifo
  import blink_pkg::*;
#(
  parameter int unsigned DW = $bits(blink_rec_t)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty
);

  logic [1:0]    r_count;
  logic [DW-1:0] r_mem0;
  logic [DW-1:0] r_mem1;
  logic          w_pop;
  logic          w_push;

  assign o_empty = (r_count == 2'd0);
  assign o_full  = (r_count == 2'd2);
  assign o_data  = r_mem0;

  // A pop frees a slot in the same cycle, so a full FIFO still takes the push.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_mem0  <= '0;
      r_mem1  <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_mem0 <= i_data;
          else                 r_mem1 <= i_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_mem0  <= r_mem1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_mem0 <= i_data;
          end else begin
            r_mem0 <= r_mem1;
            r_mem1 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/blink_monitor.sv
// Reader side of the blink LED bus: detects every change of led and emits
// one record {value, step, period, first} per change through a 2-deep buffer.
//   CLK, RST_N  clock, asynchronous active-low reset
//   enable      monitor enable; low returns to IDLE and flushes the buffer
//   led         observed LED bus (CLK domain)
//   out_if      record stream (blink_monitor_if.master)
// Optional build macro BLINK_MON_STATS_EN adds:
//   evt_count   [31:0] changes detected (saturating)
//   drop_count  [15:0] records lost to a full buffer (saturating)
// Both clear on reset and on entering IDLE.
module blink_monitor
  import blink_pkg::*;
#(
  parameter int unsigned LED_W    = BLINK_LED_W,
  parameter int unsigned PERIOD_W = BLINK_PERIOD_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              enable,
  input  logic [LED_W-1:0]  led,
  blink_monitor_if.master   out_if
`ifdef BLINK_MON_STATS_EN
  ,
  output logic [31:0]       evt_count,
  output logic [15:0]       drop_count
`endif
);

  localparam int unsigned REC_W = 2 * LED_W + PERIOD_W + 1;

  blink_mon_state_t    r_state;
  blink_mon_state_t    w_state_nxt;
  logic [LED_W-1:0]    r_led_q;
  logic [LED_W-1:0]    w_led_q_nxt;
  logic [PERIOD_W-1:0] r_cnt;
  logic [PERIOD_W-1:0] w_cnt_nxt;
  logic [PERIOD_W-1:0] w_period;
  logic [LED_W-1:0]    w_step;
  logic                w_change;
  logic                w_push;
  logic                w_first;
  logic                w_accept;
  logic                w_full;
  logic                w_empty;
  logic [REC_W-1:0]    w_rec_in;
  logic [REC_W-1:0]    w_rec_out;

  assign w_change = (led != r_led_q);
  assign w_step   = led - r_led_q;
  assign w_period = w_first ? '0 : r_cnt;
  assign w_rec_in = {led, w_step, w_period, w_first};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_led_q <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_led_q <= w_led_q_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_led_q_nxt = r_led_q;
    w_cnt_nxt   = r_cnt;
    w_push      = 1'b0;
    w_first     = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_nxt = ARMED;
          w_led_q_nxt = led;
          w_cnt_nxt   = '0;
        end
      end
      ARMED: begin
        if (!enable) begin
          w_state_nxt = IDLE;
        end else if (w_change) begin
          w_push      = 1'b1;
          w_first     = 1'b1;
          w_led_q_nxt = led;
          w_cnt_nxt   = PERIOD_W'(1);
          w_state_nxt = MEASURE;
        end
      end
      MEASURE: begin
        if (!enable) begin
          w_state_nxt = IDLE;
        end else if (w_change) begin
          w_push      = 1'b1;
          w_led_q_nxt = led;
          w_cnt_nxt   = PERIOD_W'(1);
        end else if (r_cnt != '1) begin
          w_cnt_nxt = r_cnt + PERIOD_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A record survives a full buffer only when the head leaves on the same edge;
  // otherwise it is dropped while led_q and cnt keep tracking the bus.
  assign w_accept = w_push && (!w_full || out_if.out_ready);

  blink_mon_fifo #(
    .DW (REC_W)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .i_push  (w_accept),
    .i_pop   (out_if.out_ready),
    .i_flush (!enable),
    .i_data  (w_rec_in),
    .o_data  (w_rec_out),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_if.out_valid = !w_empty;
  assign {out_if.out_value, out_if.out_step, out_if.out_period, out_if.out_first} = w_rec_out;

`ifdef BLINK_MON_STATS_EN
  logic [31:0] r_evt_count;
  logic [15:0] r_drop_count;
  logic        w_drop;
  logic        w_enter_idle;

  assign w_drop       = w_push && !w_accept;
  assign w_enter_idle = (r_state != IDLE) && (w_state_nxt == IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_evt_count  <= '0;
      r_drop_count <= '0;
    end else if (w_enter_idle) begin
      r_evt_count  <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_push && (r_evt_count != '1))  r_evt_count  <= r_evt_count + 32'd1;
      if (w_drop && (r_drop_count != '1)) r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign evt_count  = r_evt_count;
  assign drop_count = r_drop_count;
`endif

endmodule
